// File: rtl/disp_mux2.sv
// disp_mux2: two-digit 7-segment time multiplexer with per-slot blanking.
// Each digit slot is REFRESH_DIV cycles. The first BLANK_CYC cycles of a slot
// keep every anode off, and the rest of the slot shows that digit. A digit's
// pattern is latched as its slot starts, so it cannot change partway through.
// Optional build macro DISP_DIMMER_EN adds a duty[3:0] input that PWM-gates the
// segment bus while a digit is shown.
module disp_mux2 #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] unid,
    input  logic [6:0] dec,
`ifdef DISP_DIMMER_EN
    input  logic [3:0] duty,
`endif
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       slot_tick
);

    localparam int            CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST      = CW'(REFRESH_DIV - 1);
    localparam bit            NO_BLANK  = (BLANK_CYC == 0);
    localparam logic [CW-1:0] BLAST     = CW'(NO_BLANK ? 0 : BLANK_CYC - 1);
    localparam logic [6:0]    SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]    AN_OFF    = AN_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [1:0]    AN_U      = AN_OFF ^ 2'b01;
    localparam logic [1:0]    AN_D      = AN_OFF ^ 2'b10;

    typedef enum logic [1:0] {S_BLANK_U, S_SHOW_U, S_BLANK_D, S_SHOW_D} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [6:0]    cap_u, cap_d, nxt_cap_u, nxt_cap_d;
    logic [6:0]    nxt_seg;
    logic [1:0]    nxt_an;
    // Set after reset or while disabled. The first enabled edge then starts a
    // fresh units slot and captures unid on that edge.
    logic          fresh, nxt_fresh;

    // Next slot position, state, and capture registers.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_cap_u = cap_u;
        nxt_cap_d = cap_d;
        nxt_fresh = fresh;
        if (!en) begin
            nxt_state = S_BLANK_U;
            nxt_cnt   = '0;
            nxt_fresh = 1'b1;
        end else begin
            nxt_fresh = 1'b0;
            if (fresh)
                nxt_cap_u = unid;
            nxt_cnt = (cnt == LAST) ? '0 : cnt + 1'b1;
            case (state)
                S_BLANK_U: if (NO_BLANK || cnt == BLAST) nxt_state = S_SHOW_U;
                S_BLANK_D: if (NO_BLANK || cnt == BLAST) nxt_state = S_SHOW_D;
                S_SHOW_U: if (cnt == LAST) begin
                    nxt_state = NO_BLANK ? S_SHOW_D : S_BLANK_D;
                    nxt_cap_d = dec;
                end
                S_SHOW_D: if (cnt == LAST) begin
                    nxt_state = NO_BLANK ? S_SHOW_U : S_BLANK_U;
                    nxt_cap_u = unid;
                end
                default: nxt_state = S_BLANK_U;
            endcase
        end
    end

    // Output values for the coming cycle. They come from the next state, so
    // the registered outputs change on the same edge as the state.
    always_comb begin
        nxt_seg = SEG_BLANK;
        nxt_an  = AN_OFF;
        case (nxt_state)
            S_SHOW_U: begin nxt_an = AN_U; nxt_seg = nxt_cap_u; end
            S_SHOW_D: begin nxt_an = AN_D; nxt_seg = nxt_cap_d; end
            default: ;
        endcase
`ifdef DISP_DIMMER_EN
        if (4'(nxt_cnt) > duty)
            nxt_seg = SEG_BLANK;
`endif
    end

    // State and output registers. Reset takes priority over en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_BLANK_U;
            cnt   <= '0;
            cap_u <= SEG_BLANK;
            cap_d <= SEG_BLANK;
            fresh <= 1'b1;
            seg   <= SEG_BLANK;
            an    <= AN_OFF;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            cap_u <= nxt_cap_u;
            cap_d <= nxt_cap_d;
            fresh <= nxt_fresh;
            seg   <= nxt_seg;
            an    <= nxt_an;
        end
    end

    // Pulse on the last cycle of every slot while the display is enabled.
    always_comb slot_tick = en && (cnt == LAST);

endmodule

// File: tb/tb_disp_mux2.sv
// Self-checking bench for disp_mux2: a table for the basic scan, hand-written
// sequences for enable and reset corners, and random traffic compared against
// a phase-based reference model.
module tb_disp_mux2;
`ifdef DISP_DIMMER_EN
    localparam int R = 32, B = 0;
`else
    localparam int R = 8, B = 2;
`endif

    logic       clk = 1'b0;
    logic       rst, en;
    logic [6:0] unid, dec, seg;
    logic [1:0] an;
    logic       slot_tick;
`ifdef DISP_DIMMER_EN
    logic [3:0] duty;
`endif

    disp_mux2 #(.REFRESH_DIV(R), .BLANK_CYC(B), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .unid(unid), .dec(dec),
`ifdef DISP_DIMMER_EN
        .duty(duty),
`endif
        .seg(seg), .an(an), .slot_tick(slot_tick)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model. t is the position in the 2*R cycle units+tens period.
    int         t = 0;
    bit         fresh = 1'b1;
    logic [6:0] cu = 7'h7F, cd = 7'h7F;
    logic [3:0] dsm = 4'hF;

    task automatic model_edge();
        if (!rst) begin
            t = 0; fresh = 1'b1; cu = 7'h7F; cd = 7'h7F;
        end else if (!en) begin
            t = 0; fresh = 1'b1;
        end else begin
            if (fresh) cu = unid;
            fresh = 1'b0;
            if (t == R - 1)     cd = dec;
            if (t == 2 * R - 1) cu = unid;
            t = (t + 1) % (2 * R);
        end
`ifdef DISP_DIMMER_EN
        dsm = duty;
`endif
    endtask

    function automatic bit m_show();
        return !fresh && (t % R) >= B;
    endfunction

    function automatic logic [6:0] m_seg();
        if (!m_show()) return 7'h7F;
`ifdef DISP_DIMMER_EN
        if ((t % R) % 16 > int'(dsm)) return 7'h7F;
`endif
        return (t >= R) ? cd : cu;
    endfunction

    function automatic logic [1:0] m_an();
        if (!m_show()) return 2'b11;
        return (t >= R) ? 2'b01 : 2'b10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0d time=%0t)", name, act, exp, t, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_seg"}, 32'(seg), 32'(m_seg()));
        chk({tag, "_an"},  32'(an),  32'(m_an()));
        chk({tag, "_tick"}, 32'(slot_tick), 32'(en && (t % R == R - 1)));
    endtask

    task automatic mstep(input string tag);
        step();
        chk_model(tag);
    endtask

    typedef struct {
        logic [6:0] unid;
        logic [6:0] seg;
        logic [1:0] an;
        logic       tick;
    } vec_t;

    initial begin
        vec_t tbl[19];
        rst = 1'b0; en = 1'b1; unid = 7'($urandom); dec = 7'($urandom);
`ifdef DISP_DIMMER_EN
        duty = 4'($urandom);
`endif
        // Reset held for three cycles with live inputs.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_an", 32'(an), 32'h3);
            chk("rst_tick", 32'(slot_tick), 32'h0);
            unid = 7'($urandom); dec = 7'($urandom);
        end

`ifndef DISP_DIMMER_EN
        // Scan table for cycles 1..19. unid changes to 24 during cycle 4.
        for (int k = 1; k <= 19; k++) begin
            tbl[k-1].unid = (k >= 5) ? 7'h24 : 7'h40;
            tbl[k-1].tick = (k == 7 || k == 15);
            if (k >= 2 && k <= 7)        begin tbl[k-1].seg = 7'h40; tbl[k-1].an = 2'b10; end
            else if (k >= 10 && k <= 15) begin tbl[k-1].seg = 7'h79; tbl[k-1].an = 2'b01; end
            else if (k >= 18)            begin tbl[k-1].seg = 7'h24; tbl[k-1].an = 2'b10; end
            else                         begin tbl[k-1].seg = 7'h7F; tbl[k-1].an = 2'b11; end
        end
        rst = 1'b1; en = 1'b1; unid = 7'h40; dec = 7'h79;
        for (int k = 0; k < 19; k++) begin
            unid = tbl[k].unid;
            step();
            chk("scan_seg", 32'(seg), 32'(tbl[k].seg));
            chk("scan_an", 32'(an), 32'(tbl[k].an));
            chk("scan_tick", 32'(slot_tick), 32'(tbl[k].tick));
        end

        // Enable drop at cycle 12, return at cycle 20 with a new units value.
        rst = 1'b0; step(); rst = 1'b1;
        unid = 7'h06; dec = 7'h5B;
        for (int k = 1; k <= 12; k++) mstep("pre_drop");
        en = 1'b0;
        step();
        chk("endrop_seg", 32'(seg), 32'h7F);
        chk("endrop_an", 32'(an), 32'h3);
        for (int k = 14; k <= 20; k++) mstep("en_low");
        en = 1'b1; unid = 7'h12;
        step();
        chk("enret_blank_an", 32'(an), 32'h3);
        unid = 7'h33;
        step();
        chk("enret_seg", 32'(seg), 32'h12);
        chk("enret_an", 32'(an), 32'h2);

        // Reset for one cycle while tens are shown.
        for (int k = 0; k < 10; k++) mstep("pre_rst");
        chk("in_show_d_an", 32'(an), 32'h1);
        rst = 1'b0;
        step();
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_an", 32'(an), 32'h3);
        chk("midrst_tick", 32'(slot_tick), 32'h0);
        rst = 1'b1; unid = 7'h4F;
        mstep("resume"); mstep("resume");
        chk("resume_seg", 32'(seg), 32'h4F);
        for (int k = 0; k < 16; k++) mstep("resume");
`else
        // Dimmer: units shown only while cnt[3:0] <= duty.
        rst = 1'b1; en = 1'b1; unid = 7'h40; dec = 7'h79; duty = 4'd3;
        for (int k = 0; k < 64; k++) mstep("dim_run");
        for (int c = 0; c < 32; c++) begin
            chk("dim3_seg", 32'(seg), ((c % 16) <= 3) ? 32'h40 : 32'h7F);
            chk("dim3_an", 32'(an), 32'h2);
            mstep("dim3");
        end
        duty = 4'd15;
        for (int k = 0; k < 32; k++) mstep("dim_run");
        for (int c = 0; c < 32; c++) begin
            chk("dim15_seg", 32'(seg), 32'h40);
            mstep("dim15");
        end
`endif

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst  = ($urandom % 60) != 0;
            en   = ($urandom % 12) != 0;
            unid = 7'($urandom);
            dec  = 7'($urandom);
`ifdef DISP_DIMMER_EN
            duty = 4'($urandom);
`endif
            mstep("rand");
            chk("rand_onehot", 32'(an == 2'b00), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
